// File: rtl/av_matmul.sv
// Attention context: out[d] = sum_j p[j]*V[j][d], one V row per cycle over HEAD_DIM MAC lanes.
// Latency SEQ_LEN cycles from start to done; start is ignored while busy, with no queueing or stall.
module av_matmul #(
  parameter int HEAD_DIM = 4,
  parameter int SEQ_LEN  = 3,
  parameter int DW       = 4,
  parameter int PW       = 8,
  localparam int AW      = PW + DW + $clog2(SEQ_LEN)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [PW*SEQ_LEN-1:0]            p_vec,
  input  logic [DW*SEQ_LEN*HEAD_DIM-1:0]   v_mat,
  output logic                             busy,
  output logic                             done,
  output logic [AW*HEAD_DIM-1:0]           out_vec
);

  localparam int RW = $clog2(SEQ_LEN) + 1;
  localparam int MW = PW + DW;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                state;
  logic [RW-1:0]         row_idx;
  logic signed [PW-1:0]  p_lat [SEQ_LEN];
  logic signed [AW-1:0]  acc   [HEAD_DIM];

  logic signed [PW-1:0]  p_sel;
  logic signed [DW-1:0]  v_sel [HEAD_DIM];
  logic signed [MW-1:0]  prod  [HEAD_DIM];
  logic signed [AW-1:0]  sum   [HEAD_DIM];
  logic                  last_row;

  assign last_row = (row_idx == RW'(SEQ_LEN - 1));

  // Packing: p element j at [j*PW +: PW]; V element (j,d) at [(j*HEAD_DIM+d)*DW +: DW].
  always_comb begin
    p_sel = '0;
    for (int j = 0; j < SEQ_LEN; j++) begin
      if (row_idx == RW'(j)) p_sel = p_lat[j];
    end
  end

  always_comb begin
    for (int d = 0; d < HEAD_DIM; d++) begin
      v_sel[d] = '0;
      for (int j = 0; j < SEQ_LEN; j++) begin
        if (row_idx == RW'(j)) v_sel[d] = v_mat[(j*HEAD_DIM+d)*DW +: DW];
      end
    end
  end

  // Operands are sign-extended to the full product width before multiplying.
  always_comb begin
    for (int d = 0; d < HEAD_DIM; d++) begin
      prod[d] = MW'(p_sel) * MW'(v_sel[d]);
      sum[d]  = acc[d] + AW'(prod[d]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out_vec <= '0;
      for (int d = 0; d < HEAD_DIM; d++) acc[d] <= '0;
      for (int j = 0; j < SEQ_LEN; j++) p_lat[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < SEQ_LEN; j++) p_lat[j] <= p_vec[j*PW +: PW];
            for (int d = 0; d < HEAD_DIM; d++) acc[d] <= '0;
            row_idx <= '0;
            busy    <= 1'b1;
            state   <= ACC;
          end
        end
        ACC: begin
          for (int d = 0; d < HEAD_DIM; d++) acc[d] <= sum[d];
          if (last_row) begin
            for (int d = 0; d < HEAD_DIM; d++) out_vec[d*AW +: AW] <= sum[d];
            done    <= 1'b1;
            busy    <= 1'b0;
            row_idx <= '0;
            state   <= IDLE;
          end else begin
            row_idx <= row_idx + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_av_matmul.sv
// Directed and random runs of av_matmul, checked against a plain-arithmetic dot-product model.
module tb_av_matmul;

  localparam int HEAD_DIM = 4;
  localparam int SEQ_LEN  = 3;
  localparam int DW       = 4;
  localparam int PW       = 8;
  localparam int AW       = PW + DW + $clog2(SEQ_LEN);
  localparam int PERIOD   = SEQ_LEN + 1;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic [PW*SEQ_LEN-1:0]          p_vec;
  logic [DW*SEQ_LEN*HEAD_DIM-1:0] v_mat;
  logic                           busy;
  logic                           done;
  logic [AW*HEAD_DIM-1:0]         out_vec;

  int errors = 0;
  int checks = 0;
  int p [SEQ_LEN];
  int v [SEQ_LEN][HEAD_DIM];
  int p_hist [16][SEQ_LEN];
  logic signed [63:0] held [HEAD_DIM];

  av_matmul #(.HEAD_DIM(HEAD_DIM), .SEQ_LEN(SEQ_LEN), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .p_vec(p_vec), .v_mat(v_mat),
    .busy(busy), .done(done), .out_vec(out_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(int d);
    return 64'($signed(out_vec[d*AW +: AW]));
  endfunction

  function automatic logic signed [63:0] ref_out(int pl[SEQ_LEN], int d);
    longint s = 0;
    for (int j = 0; j < SEQ_LEN; j++) s += longint'(pl[j]) * longint'(v[j][d]);
    return 64'(s);
  endfunction

  task automatic drive();
    for (int j = 0; j < SEQ_LEN; j++) p_vec[j*PW +: PW] = PW'(p[j]);
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++)
        v_mat[(j*HEAD_DIM+d)*DW +: DW] = DW'(v[j][d]);
  endtask

  task automatic rand_p();
    for (int j = 0; j < SEQ_LEN; j++) p[j] = int'($urandom_range(255, 0)) - 128;
  endtask

  task automatic rand_v();
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++) v[j][d] = int'($urandom_range(15, 0)) - 8;
  endtask

  // One full run from IDLE; with poke set, start is re-pulsed and p_vec changed mid-run.
  task automatic run(string tag, bit poke);
    int pl [SEQ_LEN];
    int n;
    int nb;
    bit got;
    drive();
    pl = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on"}, 64'(busy), 64'(1));
    n = 0;
    nb = busy ? 1 : 0;
    got = 1'b0;
    while (!got && n < 4*SEQ_LEN) begin
      if (poke && n == 0) begin
        start = 1'b1;
        rand_p();
        drive();
      end
      tick();
      n++;
      start = 1'b0;
      if (done) got = 1'b1;
      else if (busy) nb++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(SEQ_LEN));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(SEQ_LEN));
    for (int d = 0; d < HEAD_DIM; d++) begin
      held[d] = ref_out(pl, d);
      chk($sformatf("%s_out%0d", tag, d), lane(d), held[d]);
    end
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int j = 0; j < SEQ_LEN; j++) p[j] = 0;
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++) v[j][d] = 0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out", 64'(out_vec), 64'(0));

    // Identity rows pick out each weight in turn.
    p = '{1, 2, 3};
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++) v[j][d] = (j == d) ? 1 : 0;
    run("t1", 1'b0);
    chk("t1_c0", lane(0), 64'(1));
    chk("t1_c1", lane(1), 64'(2));
    chk("t1_c2", lane(2), 64'(3));
    chk("t1_c3", lane(3), 64'(0));

    // Extreme operands exercise sign extension and the accumulator width.
    p = '{-128, -128, -128};
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++) v[j][d] = -8;
    run("t2neg", 1'b0);
    for (int d = 0; d < HEAD_DIM; d++) chk($sformatf("t2neg_c%0d", d), lane(d), 64'(3072));
    p = '{127, 127, 127};
    run("t2pos", 1'b0);
    for (int d = 0; d < HEAD_DIM; d++) chk($sformatf("t2pos_c%0d", d), lane(d), -64'sd3048);

    for (int k = 0; k < 6; k++) begin
      rand_p();
      rand_v();
      run($sformatf("rnd%0d", k), 1'b0);
    end

    // Start and p_vec changes while busy must not disturb the run.
    p = '{1, 1, 1};
    for (int j = 0; j < SEQ_LEN; j++)
      for (int d = 0; d < HEAD_DIM; d++) v[j][d] = 1;
    run("t3", 1'b1);
    for (int d = 0; d < HEAD_DIM; d++) chk($sformatf("t3_c%0d", d), lane(d), 64'(3));
    tick();
    chk("t3_no_requeue", 64'(busy), 64'(0));

    // Reset in the second ACC cycle discards the run.
    rand_p();
    rand_v();
    drive();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_done", 64'(done), 64'(0));
    chk("t4_out", 64'(out_vec), 64'(0));
    tick();
    chk("t4_still_idle", 64'(busy), 64'(0));
    chk("t4_no_done", 64'(done), 64'(0));
    rand_p();
    rand_v();
    run("t4_fresh", 1'b0);

    // Continuous start: a new run is accepted in every done cycle.
    rand_v();
    start = 1'b1;
    for (int e = 0; e < 3*PERIOD; e++) begin
      rand_p();
      drive();
      p_hist[e] = p;
      tick();
      if (e % PERIOD == SEQ_LEN) begin
        chk($sformatf("t5_done_e%0d", e), 64'(done), 64'(1));
        for (int d = 0; d < HEAD_DIM; d++) begin
          held[d] = ref_out(p_hist[e-SEQ_LEN], d);
          chk($sformatf("t5_e%0d_c%0d", e, d), lane(d), held[d]);
        end
      end else begin
        chk($sformatf("t5_nodone_e%0d", e), 64'(done), 64'(0));
      end
    end
    start = 1'b0;

    // Results hold while idle even as V changes underneath.
    for (int k = 0; k < 10; k++) begin
      rand_v();
      drive();
      tick();
      chk($sformatf("t6_busy%0d", k), 64'(busy), 64'(0));
      chk($sformatf("t6_done%0d", k), 64'(done), 64'(0));
      for (int d = 0; d < HEAD_DIM; d++)
        chk($sformatf("t6_k%0d_c%0d", k, d), lane(d), held[d]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
